alarm_zone_ctrl: RTL
====================

Name: alarm_zone_ctrl

Overview:
Multi-zone successor to the single-sensor house alarm. Monitors N window/door sensors under a global RUN arm. After a programmable entry delay (DTF) it drives the siren output for a programmable ring time (RTR). Sits between the sensor debouncers and the siren/display logic of the thermostat house system. Adds per-zone enable and latching, a tick prescaler, optional auto-rearm, continuous-ring mode and an alarm event counter.

Parameters:
N_ZONES, 4, number of sensor inputs
DTF_W, 5, width of entry-delay value (ticks)
RTR_W, 6, width of ring-time value (ticks)
TICK_DIV, 1, clk cycles per tick; 1 = every cycle
AUTO_REARM, 0, 1 = return to ARMED at ring end if no enabled sensor is asserted
CNT_W, 8, width of the alarm event counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
RUN  in  1  arm; 0 forces IDLE
ws  in  N_ZONES  sensor levels, 1 = open
zone_en  in  N_ZONES  per-zone enable mask
CLR_WC  in  1  acknowledge/clear pulse during entry delay
restart  in  1  re-arm pulse after alarm
DTF  in  DTF_W  entry delay in ticks
RTR  in  RTR_W  ring time in ticks; 0 = ring until restart
active  out  1  siren drive
pending  out  1  entry delay running
zones  out  N_ZONES  latched triggering zones
alarm_cnt  out  CNT_W  alarms since reset, saturating

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; active=0, pending=0, zones=0, alarm_cnt=0; prescaler and counters cleared. rst has priority over all inputs.
- Outputs are registered. trig = |(ws & zone_en).
- tick: pulses for 1 clk every TICK_DIV cycles. Prescaler runs only in PENDING/ALARM and restarts at 0 on each state entry.
- IDLE: all outputs 0 except alarm_cnt. RUN=1 -> ARMED next cycle.
- ARMED: on trig, go to PENDING with:
  - zones <= ws & zone_en
  - delay counter <= DTF
  - pending=1 from the next cycle
  - if DTF=0, go straight to ALARM instead.
- PENDING:
  - CLR_WC=1 -> ARMED; zones cleared; pending=0.
  - Otherwise the counter decrements on each tick. Reaching 0 -> ALARM.
  - New triggering zones OR into zones.
- ALARM entry: active=1, pending=0, ring counter <= RTR, alarm_cnt+1 (saturates at all-ones).
- ALARM:
  - Counter decrements on each tick; zones keep OR-ing.
  - Counter reaches 0 with RTR≠0:
    - AUTO_REARM=1 and trig=0 -> ARMED, zones cleared.
    - Otherwise -> HOLD.
  - RTR=0: ring until restart.
  - restart=1 -> ARMED, active=0, zones cleared.
- HOLD: active=0, zones held. restart=1 -> ARMED, zones cleared.
- RUN=0 in any state -> IDLE next cycle, clearing active/pending/zones. RUN has priority over CLR_WC/restart/expiry.
- DTF and RTR are sampled only on counter load; later changes do not affect a running count.
- Simultaneous events:
  - CLR_WC with delay expiry -> CLR_WC wins (ARMED).
  - restart with ring expiry -> restart wins (ARMED).
  - restart outside ALARM/HOLD and CLR_WC outside PENDING are ignored.
- Latency:
  - Sensor assert to pending=1: 1 cycle.
  - Sensor assert to active=1: (DTF·TICK_DIV)+1 cycles; 1 cycle when DTF=0.

Decomposition:
- Package alarm_pkg: state enum (IDLE, ARMED, PENDING, ALARM, HOLD) and default width constants.
- One sub-module: alarm_down_counter (parametrised width, load, tick-enable decrement, zero flag). Instantiated twice, for delay and ring.
- Prescaler and FSM stay in the top level.

Test Plan (N_ZONES=4, TICK_DIV=1):
- Reset mid-ALARM: rst=1 for 1 cycle -> next cycle active=0, zones=0, alarm_cnt=0, state IDLE.
- RUN=1, zone_en=4'b0011, DTF=12, RTR=12; ws=4'b0001 -> pending=1 next cycle, active=1 after 13 cycles for 12 cycles, then HOLD; restart -> ARMED, zones=0; alarm_cnt=1.
- ws=4'b0100 with zone_en=4'b0011 -> no pending. During PENDING (DTF=7), pulse CLR_WC at count 3 -> ARMED, active never asserts.
- DTF=0 -> active=1 one cycle after ws. RTR=0 -> active held 100 cycles until restart; restart and expiry in the same cycle (RTR=5) -> ARMED.
- AUTO_REARM=1, RTR=6, ws released before expiry -> ARMED; ws held -> HOLD. Zones 0 then 1 triggered during the delay -> zones=4'b0011.
- TICK_DIV=4, DTF=3 -> active at cycle 13; RUN dropped in PENDING -> IDLE next cycle. 256 alarms with CNT_W=8 -> alarm_cnt saturates at 255.

Source files
------------

// File: rtl/alarm_zone_ctrl_pkg.sv
// alarm_pkg: shared types and default widths for the multi-zone alarm controller.
//   - alarm_state_e : controller state encoding
//   - DEF_*         : default widths used by the interface and top level
package alarm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_PENDING = 3'd2,
    ST_ALARM   = 3'd3,
    ST_HOLD    = 3'd4
  } alarm_state_e;

  localparam int DEF_N_ZONES = 4;
  localparam int DEF_DTF_W   = 5;
  localparam int DEF_RTR_W   = 6;
  localparam int DEF_CNT_W   = 8;

endpackage

// File: rtl/alarm_zone_ctrl_if.sv
// alarm_zone_ctrl_if: groups the sensor/control inputs and the siren/display
// outputs of alarm_zone_ctrl.
//   master : environment side (drives RUN, ws, zone_en, CLR_WC, restart, DTF, RTR)
//   slave  : controller side (drives active, pending, zones, alarm_cnt)
interface alarm_zone_ctrl_if
  import alarm_pkg::*;
#(
  parameter int N_ZONES = DEF_N_ZONES,
  parameter int DTF_W   = DEF_DTF_W,
  parameter int RTR_W   = DEF_RTR_W,
  parameter int CNT_W   = DEF_CNT_W
);

  logic               RUN;
  logic [N_ZONES-1:0] ws;
  logic [N_ZONES-1:0] zone_en;
  logic               CLR_WC;
  logic               restart;
  logic [DTF_W-1:0]   DTF;
  logic [RTR_W-1:0]   RTR;
  logic               active;
  logic               pending;
  logic [N_ZONES-1:0] zones;
  logic [CNT_W-1:0]   alarm_cnt;

  modport master (
    output RUN, ws, zone_en, CLR_WC, restart, DTF, RTR,
    input  active, pending, zones, alarm_cnt
  );

  modport slave (
    input  RUN, ws, zone_en, CLR_WC, restart, DTF, RTR,
    output active, pending, zones, alarm_cnt
  );

endinterface

// File: rtl/alarm_down_counter.sv
// alarm_down_counter: loadable down counter with tick-enabled decrement.
//   clk, rst : clock, synchronous active-high reset
//   load_i   : load val_i (has priority over tick_i)
//   val_i    : load value
//   tick_i   : decrement enable; the count holds at zero
//   zero_o   : high on the tick that takes the count from 1 to 0
module alarm_down_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  input  logic         tick_i,
  output logic         zero_o
);

  logic [W-1:0] count_q;

  // Count register: load, decrement on tick, never wraps below zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= val_i;
    end else if (tick_i && (count_q != '0)) begin
      count_q <= count_q - W'(1);
    end else begin
      count_q <= count_q;
    end
  end

  // A loaded zero never produces zero_o, which gives the "ring forever" case.
  assign zero_o = tick_i && (count_q == W'(1));

endmodule

// File: rtl/alarm_zone_ctrl.sv
// alarm_zone_ctrl: multi-zone alarm controller.
//   clk, rst : clock, synchronous active-high reset
//   bus      : alarm_zone_ctrl_if.slave
//              in : RUN, ws, zone_en, CLR_WC, restart, DTF, RTR
//              out: active, pending, zones, alarm_cnt (all registered)
// An enabled open sensor starts the entry delay (DTF ticks); when it runs out
// the siren rings for RTR ticks (0 = until restart).
module alarm_zone_ctrl
  import alarm_pkg::*;
#(
  parameter int N_ZONES    = DEF_N_ZONES,
  parameter int DTF_W      = DEF_DTF_W,
  parameter int RTR_W      = DEF_RTR_W,
  parameter int TICK_DIV   = 1,
  parameter int AUTO_REARM = 0,
  parameter int CNT_W      = DEF_CNT_W
) (
  input logic              clk,
  input logic              rst,
  alarm_zone_ctrl_if.slave bus
);

  localparam int             PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);

  alarm_state_e       state_q, state_d;
  logic [PW-1:0]      presc_q, presc_d;
  logic [N_ZONES-1:0] zones_q, zones_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               active_q, pending_q;
  logic [N_ZONES-1:0] trig_vec_s;
  logic               trig_s, tick_s, timed_s;
  logic               dly_load_s, ring_load_s, dly_zero_s, ring_zero_s;

  assign trig_vec_s = bus.ws & bus.zone_en;
  assign trig_s     = |trig_vec_s;
  assign timed_s    = (state_q == ST_PENDING) || (state_q == ST_ALARM);
  assign tick_s     = timed_s && (presc_q == PRESC_LAST);

  alarm_down_counter #(.W(DTF_W)) u_delay (
    .clk    (clk),
    .rst    (rst),
    .load_i (dly_load_s),
    .val_i  (bus.DTF),
    .tick_i (tick_s && (state_q == ST_PENDING)),
    .zero_o (dly_zero_s)
  );

  alarm_down_counter #(.W(RTR_W)) u_ring (
    .clk    (clk),
    .rst    (rst),
    .load_i (ring_load_s),
    .val_i  (bus.RTR),
    .tick_i (tick_s && (state_q == ST_ALARM)),
    .zero_o (ring_zero_s)
  );

  // Next state, zone latch and counter loads; RUN=0 overrides everything else.
  always_comb begin
    state_d     = state_q;
    zones_d     = zones_q;
    dly_load_s  = 1'b0;
    ring_load_s = 1'b0;
    if (!bus.RUN) begin
      state_d = ST_IDLE;
      zones_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_ARMED;
          zones_d = '0;
        end
        ST_ARMED: begin
          if (trig_s) begin
            zones_d = trig_vec_s;
            if (bus.DTF == '0) begin
              state_d     = ST_ALARM;
              ring_load_s = 1'b1;
            end else begin
              state_d    = ST_PENDING;
              dly_load_s = 1'b1;
            end
          end else begin
            zones_d = '0;
          end
        end
        ST_PENDING: begin
          if (bus.CLR_WC) begin
            state_d = ST_ARMED;
            zones_d = '0;
          end else begin
            zones_d = zones_q | trig_vec_s;
            if (dly_zero_s) begin
              state_d     = ST_ALARM;
              ring_load_s = 1'b1;
            end else begin
              state_d = ST_PENDING;
            end
          end
        end
        ST_ALARM: begin
          if (bus.restart) begin
            state_d = ST_ARMED;
            zones_d = '0;
          end else if (ring_zero_s) begin
            // Auto re-arm only when no enabled sensor is still open.
            if ((AUTO_REARM != 0) && !trig_s) begin
              state_d = ST_ARMED;
              zones_d = '0;
            end else begin
              state_d = ST_HOLD;
              zones_d = zones_q | trig_vec_s;
            end
          end else begin
            zones_d = zones_q | trig_vec_s;
          end
        end
        ST_HOLD: begin
          if (bus.restart) begin
            state_d = ST_ARMED;
            zones_d = '0;
          end else begin
            state_d = ST_HOLD;
          end
        end
        default: begin
          state_d = ST_IDLE;
          zones_d = '0;
        end
      endcase
    end
  end

  // Saturating alarm event counter, bumped on every ALARM entry.
  always_comb begin
    if (ring_load_s && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Tick prescaler: restarts on every state change, idles outside PENDING/ALARM.
  always_comb begin
    if (state_d != state_q) begin
      presc_d = '0;
    end else if (timed_s) begin
      presc_d = tick_s ? '0 : (presc_q + PW'(1));
    end else begin
      presc_d = '0;
    end
  end

  // State and registered outputs; outputs follow the next state directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      presc_q   <= '0;
      zones_q   <= '0;
      cnt_q     <= '0;
      active_q  <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      zones_q   <= zones_d;
      cnt_q     <= cnt_d;
      active_q  <= (state_d == ST_ALARM);
      pending_q <= (state_d == ST_PENDING);
    end
  end

  assign bus.active    = active_q;
  assign bus.pending   = pending_q;
  assign bus.zones     = zones_q;
  assign bus.alarm_cnt = cnt_q;

endmodule
